// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path.
// Holds the opcode constants, the 4-bit control state encoding, and the
// alu_op / pc_source / alu_src_b select codes used by the control FSM
// and its output decoder.
package mips_pkg;

    // Instruction opcodes (instruction[31:26]) handled by the control FSM.
    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    // Control FSM states; encodings 12..15 are unused.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    // alu_op codes passed to the ALU control.
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // pc_source select codes.
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // alu_src_b select codes.
    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // True when the opcode is one the FSM knows how to sequence.
    function automatic logic is_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_J) || (op == OP_BEQ) ||
               (op == OP_ADDI)  || (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational output decoder for the multicycle control FSM.
// Maps the current state (plus mem_ready, which gates the FETCH-cycle
// register loads) onto the datapath control signals.
// Ports:
//   state      in   current FSM state encoding
//   mem_ready  in   memory completed its access this cycle
//   pc_write .. reg_dst  out  datapath control signals (Moore style)
module multicycle_control_decode
    import mips_pkg::*;
(
    input  logic [3:0] state,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       ir_write,
    output logic [1:0] pc_source,
    output logic [1:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       reg_write,
    output logic       reg_dst
);

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        ir_write      = 1'b0;
        pc_source     = PCSRC_ALU;
        alu_op        = ALU_ADD;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;

        case (state)
            S_FETCH: begin
                // PC+4 is computed every FETCH cycle, but the IR and PC only
                // load once the instruction word has actually arrived.
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut.
                alu_src_b = SRCB_IMM_SH2;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Sequences the shared memory and ALU over 3..5 states per instruction,
// waits on the memory-ready handshake, and counts retired instructions.
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   opcode             instruction[31:26] from the instruction register
//   mem_ready          memory access completes this cycle
//   pc_write .. reg_dst  datapath control outputs
//   illegal_op         DECODE cycle with an unsupported opcode
//   state_out          current state encoding (debug)
//   instret            retired-instruction count, wraps
module multicycle_control
    import mips_pkg::*;
#(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           opcode,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 pc_write_cond,
    output logic                 i_or_d,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 mem_to_reg,
    output logic                 ir_write,
    output logic [1:0]           pc_source,
    output logic [1:0]           alu_op,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic                 reg_write,
    output logic                 reg_dst,
    output logic                 illegal_op,
    output logic [3:0]           state_out,
    output logic [INSTRET_W-1:0] instret
);

    localparam logic [INSTRET_W-1:0] INSTRET_ONE = {{(INSTRET_W-1){1'b0}}, 1'b1};

    state_t                 state_reg;
    state_t                 state_next;
    logic                   retire;
    logic [INSTRET_W-1:0]   instret_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_FETCH;
            instret_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (retire) begin
                instret_reg <= instret_reg + INSTRET_ONE;
            end
        end
    end

    // Next state and retire strobe. retire marks the last cycle of a
    // legal instruction, i.e. the edge that returns to FETCH.
    always_comb begin
        state_next = state_reg;
        retire     = 1'b0;
        case (state_reg)
            S_FETCH: begin
                if (mem_ready) state_next = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXECUTE;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_J:         state_next = S_JUMP;
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                state_next = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                if (mem_ready) state_next = S_MEMWB;
            end
            S_MEMWRITE: begin
                if (mem_ready) begin
                    state_next = S_FETCH;
                    retire     = 1'b1;
                end
            end
            S_EXECUTE: state_next = S_ALUWB;
            S_ADDIEX:  state_next = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
                state_next = S_FETCH;
                retire     = 1'b1;
            end
            default: state_next = S_FETCH;
        endcase
    end

    multicycle_control_decode u_decode (
        .state         (state_reg),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_to_reg    (mem_to_reg),
        .ir_write      (ir_write),
        .pc_source     (pc_source),
        .alu_op        (alu_op),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst)
    );

    assign illegal_op = (state_reg == S_DECODE) && !is_supported(opcode);
    assign state_out  = state_reg;
    assign instret    = instret_reg;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath. It replaces the single-cycle opcode decoder.
- One shared memory serves both instruction fetch and data access, selected by i_or_d. A single ALU serves PC increment, branch target, address and arithmetic.
- The block sequences these shared resources across 3–5 states per instruction.
- It waits on a memory-ready handshake and counts retired instructions.

Parameters:
- INSTRET_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  6  instruction[31:26] from the instruction register, stable after FETCH.
- mem_ready  in  1  memory has completed the current read/write this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero (branch).
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- mem_to_reg  out  1  write-back source: 1 = MDR, 0 = ALUOut.
- ir_write  out  1  instruction register load.
- pc_source  out  2  00 = ALU result, 01 = ALUOut (branch target), 10 = jump target.
- alu_op  out  2  00 = add, 01 = sub, 10 = funct-driven (feeds the existing ALU control).
- alu_src_a  out  1  0 = PC, 1 = register A.
- alu_src_b  out  2  00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- reg_write  out  1  register bank write enable.
- reg_dst  out  1  1 = rd, 0 = rt.
- illegal_op  out  1  high during a DECODE cycle with an unsupported opcode.
- state_out  out  4  current state encoding, for debug.
- instret  out  INSTRET_W  count of retired instructions.

Behaviour:
- Supported opcodes: 0 = R-type, 2 = j, 4 = beq, 8 = addi, 35 = lw, 43 = sw.
- Output style: Moore outputs decoded from the state register. The only exception is that ir_write and pc_write in FETCH are gated by mem_ready. Any output not listed for a state is 0.
- State encodings, outputs and transitions:
  - FETCH (0): mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00, ir_write=pc_write=mem_ready. Stays while mem_ready=0; goes to DECODE when mem_ready=1.
  - DECODE (1): alu_src_a=0, alu_src_b=11, alu_op=00, so the branch target goes into ALUOut. Next state by opcode:
    - lw/sw -> MEMADR
    - R-type -> EXECUTE
    - beq -> BRANCH
    - addi -> ADDIEX
    - j -> JUMP
    - any other opcode -> FETCH, with illegal_op=1 this cycle
  - MEMADR (2): alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD (3): mem_read=1, i_or_d=1. Holds until mem_ready, then MEMWB.
  - MEMWB (4): reg_write=1, mem_to_reg=1, reg_dst=0. Then FETCH.
  - MEMWRITE (5): mem_write=1, i_or_d=1. Holds until mem_ready, then FETCH.
  - EXECUTE (6): alu_src_a=1, alu_src_b=00, alu_op=10. Then ALUWB.
  - ALUWB (7): reg_write=1, reg_dst=1, mem_to_reg=0. Then FETCH.
  - BRANCH (8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Then FETCH.
  - ADDIEX (9): alu_src_a=1, alu_src_b=10, alu_op=00. Then ADDIWB.
  - ADDIWB (10): reg_write=1, reg_dst=0, mem_to_reg=0. Then FETCH.
  - JUMP (11): pc_write=1, pc_source=10. Then FETCH.
  - Encodings 12–15: unreachable; next state = FETCH, all outputs 0.
- Latency with mem_ready held high (cycles from FETCH to next FETCH): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each cycle with mem_ready low in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Handshake:
  - mem_read and mem_write are held stable until the cycle in which mem_ready=1.
  - mem_read and mem_write are never asserted together.
  - A mem_ready pulse outside FETCH, MEMREAD or MEMWRITE is ignored.
- instret:
  - Increments by 1 on the clock edge that leaves a terminal state: MEMWB, MEMWRITE (with mem_ready), ALUWB, BRANCH, ADDIWB, JUMP.
  - Does not increment for an illegal opcode.
  - Wraps modulo 2^INSTRET_W.
- Reset:
  - reset=1 at a clock edge sets state to FETCH and instret to 0. This applies in any state, including mid-instruction or during a memory wait.
  - reset has priority over all transitions and over the instret increment.
  - After reset the outputs are the FETCH decode: mem_read=1, all write enables equal to mem_ready gating. While reset is held with mem_ready=1, pc_write and ir_write may assert; the datapath ignores them because it is also in reset.
  - An aborted MEMWRITE drops mem_write on the cycle after the reset edge.
- opcode is sampled only in DECODE and MEMADR. Changes at other times have no effect.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants (OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW)
  - the 4-bit state encoding constants above
  - alu_op codes (ADD=00, SUB=01, FUNCT=10)
  - pc_source codes and alu_src_b codes
- One sub-module, multicycle_control_decode: purely combinational, maps state and mem_ready to the control outputs.
- The top-level module holds the state register, next-state logic and the instret counter.

Test Plan:
- Reset then a lw sequence (opcode=35, mem_ready=1) -> states 0,2... specifically 0,1,2,3,4,0. reg_write=1 and mem_to_reg=1 only in state 4. instret=1 after 5 cycles.
- sw with mem_ready low for 3 cycles in MEMWRITE -> mem_write held for 4 cycles and i_or_d=1 throughout; back in FETCH after 7 cycles total; instret increments once.
- beq (4), j (2), addi (8), R-type (0) back to back, mem_ready=1 -> cycle counts 3, 3, 4, 4. In state 8: pc_write_cond=1, pc_source=01, alu_op=01. In state 11: pc_write=1, pc_source=10. instret=4.
- Illegal opcode 6'h3F -> illegal_op=1 for exactly the DECODE cycle, then FETCH; instret unchanged.
- FETCH with mem_ready=0 for 5 cycles -> ir_write=0 and pc_write=0 throughout; state_out=0; advances to DECODE one cycle after mem_ready rises.
- reset asserted in MEMREAD during a wait -> state_out=0 and instret=0 next cycle; mem_read stays 1 with i_or_d=0; no reg_write pulse.
